// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction-fetch stage between preif and ID.
// Tracks the PC of every issued fetch, pairs in-order inst_sram responses
// with those PCs, buffers completed fetches in a DEPTH-entry FIFO and
// presents up to ISSUE_WIDTH instructions per cycle to ID. An exception
// flush empties the stage and drops the responses still in flight.
//
// Optional feature (macro IF_BYPASS_EN): a response arriving while the FIFO
// is empty is shown on lane 0 in the same cycle. If ID takes it, the FIFO
// is not written.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   excep_flush_i            exception/ertn flush
//   interrupt_en_i           pending interrupt, tags lane 0
//   pi_valid_i, pi_pc_i      request issued by preif and its PC
//   if_allowin_o             preif may issue this cycle
//   inst_sram_data_ok_i      in-order fetch response strobe
//   inst_sram_rdata_i        fetch response data
//   id_allowin_i             ID consumes every valid lane this cycle
//   if_to_id_*_o             per-lane valid/pc/inst/adef/int/excep_en
//   fifo_count_o             FIFO occupancy
module if_fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned ISSUE_WIDTH     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned INST_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              excep_flush_i,
  input  logic                              interrupt_en_i,
  input  logic                              pi_valid_i,
  input  logic [PC_WIDTH-1:0]               pi_pc_i,
  output logic                              if_allowin_o,
  input  logic                              inst_sram_data_ok_i,
  input  logic [INST_WIDTH-1:0]             inst_sram_rdata_i,
  input  logic                              id_allowin_i,
  output logic [ISSUE_WIDTH-1:0]            if_to_id_valid_o,
  output logic [ISSUE_WIDTH*PC_WIDTH-1:0]   if_to_id_pc_o,
  output logic [ISSUE_WIDTH*INST_WIDTH-1:0] if_to_id_inst_o,
  output logic [ISSUE_WIDTH-1:0]            if_to_id_adef_o,
  output logic [ISSUE_WIDTH-1:0]            if_to_id_int_o,
  output logic [ISSUE_WIDTH-1:0]            if_to_id_excep_en_o,
  output logic [$clog2(DEPTH+1)-1:0]        fifo_count_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QPTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Completed-fetch FIFO
  logic [PC_WIDTH-1:0]   fpc_q   [DEPTH];
  logic [INST_WIDTH-1:0] finst_q [DEPTH];
  logic [DEPTH-1:0]      fadef_q;
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;

  // PCs of issued-but-unanswered requests, oldest at pcq_rd_q
  logic [PC_WIDTH-1:0]   pcq_q [MAX_OUTSTANDING];
  logic [QPTR_W-1:0]     pcq_rd_q, pcq_wr_q;
  logic [OUT_W-1:0]      outst_q;
  logic [OUT_W-1:0]      cancel_q;

  logic                  accept_c, resp_c, drop_c, push_c, byp_take_c, int0_c;
  logic [PC_WIDTH-1:0]   resp_pc_c;
  logic                  resp_adef_c;
  logic [CNT_W-1:0]      pop_cnt_c;
  logic [31:0]           cancel_sum_c;
  logic [ISSUE_WIDTH-1:0]            valid_c, adef_c, int_c;
  logic [ISSUE_WIDTH*PC_WIDTH-1:0]   pc_c;
  logic [ISSUE_WIDTH*INST_WIDTH-1:0] inst_c;
`ifdef IF_BYPASS_EN
  logic                  byp_c;
`endif

  // Admission: keeps room for cancelled responses and a FIFO slot per request
  assign if_allowin_o = !excep_flush_i
                     && ((32'(outst_q) + 32'(cancel_q)) < MAX_OUTSTANDING)
                     && ((32'(outst_q) + 32'(count_q)) < DEPTH);

  assign accept_c    = pi_valid_i && if_allowin_o;
  assign drop_c      = inst_sram_data_ok_i && (cancel_q != '0);
  assign resp_c      = inst_sram_data_ok_i && (cancel_q == '0);
  assign resp_pc_c   = pcq_q[pcq_rd_q];
  assign resp_adef_c = (resp_pc_c[1:0] != 2'b00);
  assign push_c      = resp_c && !byp_take_c;

  // Lane selection from the FIFO head (plus optional same-cycle bypass)
  always_comb begin
    valid_c    = '0;
    adef_c     = '0;
    int_c      = '0;
    pc_c       = '0;
    inst_c     = '0;
    pop_cnt_c  = '0;
    byp_take_c = 1'b0;
    int0_c     = 1'b0;
`ifdef IF_BYPASS_EN
    byp_c      = 1'b0;
`endif
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      if (!excep_flush_i && (32'(count_q) > k)) valid_c[k] = 1'b1;
    end
`ifdef IF_BYPASS_EN
    if (resp_c && (count_q == '0) && !excep_flush_i) begin
      valid_c[0] = 1'b1;
      byp_c      = 1'b1;
    end
`endif
    // An interrupt is taken on the oldest instruction only
    int0_c = interrupt_en_i && valid_c[0];
    if (int0_c) begin
      for (int unsigned k = 1; k < ISSUE_WIDTH; k++) valid_c[k] = 1'b0;
    end
    int_c[0] = int0_c;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      if (valid_c[k]) begin
        pc_c[k*PC_WIDTH +: PC_WIDTH]       = fpc_q[rd_ptr_q + PTR_W'(k)];
        inst_c[k*INST_WIDTH +: INST_WIDTH] = finst_q[rd_ptr_q + PTR_W'(k)];
        adef_c[k]                          = fadef_q[rd_ptr_q + PTR_W'(k)];
        if (id_allowin_i) pop_cnt_c = pop_cnt_c + CNT_W'(1);
      end
    end
`ifdef IF_BYPASS_EN
    if (byp_c) begin
      pc_c[PC_WIDTH-1:0]     = resp_pc_c;
      inst_c[INST_WIDTH-1:0] = inst_sram_rdata_i;
      adef_c[0]              = resp_adef_c;
      pop_cnt_c              = '0;
      byp_take_c             = id_allowin_i;
    end
`endif
  end

  assign if_to_id_valid_o    = valid_c;
  assign if_to_id_pc_o       = pc_c;
  assign if_to_id_inst_o     = inst_c;
  assign if_to_id_adef_o     = adef_c;
  assign if_to_id_int_o      = int_c;
  assign if_to_id_excep_en_o = (adef_c | int_c) & valid_c;
  assign fifo_count_o        = count_q;

  // Responses still owed after a flush; the one arriving now is already paid
  always_comb begin
    cancel_sum_c = 32'(cancel_q) + 32'(outst_q);
    if (inst_sram_data_ok_i && (cancel_sum_c != 32'd0)) cancel_sum_c = cancel_sum_c - 32'd1;
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pcq_rd_q <= '0;
      pcq_wr_q <= '0;
      outst_q  <= '0;
      cancel_q <= '0;
    end else if (excep_flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pcq_rd_q <= '0;
      pcq_wr_q <= '0;
      outst_q  <= '0;
      cancel_q <= OUT_W'(cancel_sum_c);
    end else begin
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_cnt_c);
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      count_q  <= count_q + CNT_W'(push_c) - pop_cnt_c;
      if (accept_c) begin
        pcq_wr_q <= (pcq_wr_q == QPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : pcq_wr_q + QPTR_W'(1);
      end
      if (resp_c) begin
        pcq_rd_q <= (pcq_rd_q == QPTR_W'(MAX_OUTSTANDING - 1)) ? '0 : pcq_rd_q + QPTR_W'(1);
      end
      outst_q  <= outst_q + OUT_W'(accept_c) - OUT_W'(resp_c);
      if (drop_c) cancel_q <= cancel_q - OUT_W'(1);
    end
  end

  // Payload storage; validity is tracked by the pointers and counters
  always_ff @(posedge clk) begin
    if (!rst && !excep_flush_i) begin
      if (push_c) begin
        fpc_q[wr_ptr_q]   <= resp_pc_c;
        finst_q[wr_ptr_q] <= inst_sram_rdata_i;
        fadef_q[wr_ptr_q] <= resp_adef_c;
      end
      if (accept_c) pcq_q[pcq_wr_q] <= pi_pc_i;
    end
  end

  // Overflow / underflow guards
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inst_sram_data_ok_i && (cancel_q == '0) && (outst_q == '0)));
      assert (!(accept_c && (32'(outst_q) >= MAX_OUTSTANDING)));
      assert ((32'(count_q) + 32'(push_c)) <= (DEPTH + 32'(pop_cnt_c)));
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue (default build, DEPTH=4, ISSUE_WIDTH=2,
// MAX_OUTSTANDING=2): directed vectors, corner sequences, random traffic.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int MO    = 2;

  logic        clk = 1'b0;
  logic        rst, fl, it, pv, dok, ida;
  logic [31:0] pc, rd;
  logic        allow_o;
  logic [1:0]  valid_o, adef_o, int_o, excep_o;
  logic [63:0] pc_o, inst_o;
  logic [2:0]  cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk                 (clk),
    .rst                 (rst),
    .excep_flush_i       (fl),
    .interrupt_en_i      (it),
    .pi_valid_i          (pv),
    .pi_pc_i             (pc),
    .if_allowin_o        (allow_o),
    .inst_sram_data_ok_i (dok),
    .inst_sram_rdata_i   (rd),
    .id_allowin_i        (ida),
    .if_to_id_valid_o    (valid_o),
    .if_to_id_pc_o       (pc_o),
    .if_to_id_inst_o     (inst_o),
    .if_to_id_adef_o     (adef_o),
    .if_to_id_int_o      (int_o),
    .if_to_id_excep_en_o (excep_o),
    .fifo_count_o        (cnt_o)
  );

  // Reference model: plain queues of pending PCs and completed fetches
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;
  ent_t        mfifo[$];
  logic [31:0] mpend[$];
  int          mcancel = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_lanes();
    int n;
    n = fl ? 0 : ((mfifo.size() > 2) ? 2 : mfifo.size());
    if (it && n > 0) n = 1;
    return n;
  endfunction

  function automatic logic m_allow();
    return !fl && ((mpend.size() + mcancel) < MO) && ((mpend.size() + mfifo.size()) < DEPTH);
  endfunction

  task automatic check_model();
    int          n;
    logic [1:0]  ev, ea, ei;
    logic [63:0] ep, ein;
    n = m_lanes();
    ev = '0; ea = '0; ep = '0; ein = '0;
    for (int k = 0; k < n; k++) begin
      ev[k]          = 1'b1;
      ep[k*32 +: 32]  = mfifo[k].pc;
      ein[k*32 +: 32] = mfifo[k].inst;
      ea[k]          = mfifo[k].adef;
    end
    ei = {1'b0, it && (n > 0)};
    chk("allowin", 64'(allow_o), 64'(m_allow()));
    chk("valid",   64'(valid_o), 64'(ev));
    chk("pc",      pc_o, ep);
    chk("inst",    inst_o, ein);
    chk("adef",    64'(adef_o), 64'(ea));
    chk("int",     64'(int_o), 64'(ei));
    chk("excep",   64'(excep_o), 64'((ea | ei) & ev));
    chk("count",   64'(cnt_o), 64'(mfifo.size()));
  endtask

  // Clock edge: update the model from the inputs held across the edge
  task automatic advance();
    int          n, t;
    logic        acc;
    logic [31:0] p;
    ent_t        e;
    n   = m_lanes();
    acc = pv && m_allow();
    @(posedge clk);
    if (rst) begin
      mfifo.delete(); mpend.delete(); mcancel = 0;
    end else if (fl) begin
      t = mcancel + mpend.size() - (dok ? 1 : 0);
      mcancel = (t < 0) ? 0 : t;
      mfifo.delete(); mpend.delete();
    end else begin
      if (ida) repeat (n) void'(mfifo.pop_front());
      if (dok) begin
        if (mcancel > 0) mcancel--;
        else begin
          p = mpend.pop_front();
          e.pc = p; e.inst = rd; e.adef = (p[1:0] != 2'b00);
          mfifo.push_back(e);
        end
      end
      if (acc) mpend.push_back(pc);
    end
    @(negedge clk);
  endtask

  task automatic drv(input logic f, input logic i, input logic v, input logic [31:0] p,
                     input logic d, input logic [31:0] r, input logic a);
    fl = f; it = i; pv = v; pc = p; dok = d; rd = r; ida = a;
  endtask

  task automatic cyc();
    #1;
    check_model();
    advance();
  endtask

  typedef struct {
    logic f, i, v; logic [31:0] p; logic d; logic [31:0] r; logic a;
    logic [1:0] ev; logic [31:0] epc0, einst0; logic [1:0] eex; logic eal; logic [2:0] ecnt;
  } vec_t;
  vec_t tbl[20];

  initial begin
    logic [31:0] rp;
    int          pct;

    // f i v pc d rdata ida | valid pc0 inst0 excep allowin count
    tbl[0]  = '{0,0,1,32'h1c000000,0,32'h0,1,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[1]  = '{0,0,0,32'h0,0,32'h0,1,               2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[2]  = '{0,0,0,32'h0,1,32'h02800000,1,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[3]  = '{0,0,0,32'h0,0,32'h0,1,               2'b01,32'h1c000000,32'h02800000,2'b00,1,3'd1};
    tbl[4]  = '{0,0,1,32'h1c000002,0,32'h0,0,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[5]  = '{0,0,0,32'h0,1,32'h02800000,0,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[6]  = '{0,0,0,32'h0,0,32'h0,1,               2'b01,32'h1c000002,32'h02800000,2'b01,1,3'd1};
    tbl[7]  = '{0,0,1,32'h1c000010,0,32'h0,0,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[8]  = '{0,0,1,32'h1c000014,1,32'h00000013,0, 2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[9]  = '{0,0,0,32'h0,1,32'h00000093,0,        2'b01,32'h1c000010,32'h00000013,2'b00,1,3'd1};
    tbl[10] = '{0,1,0,32'h0,0,32'h0,0,               2'b01,32'h1c000010,32'h00000013,2'b01,1,3'd2};
    tbl[11] = '{0,0,0,32'h0,0,32'h0,1,               2'b11,32'h1c000010,32'h00000013,2'b00,1,3'd2};
    tbl[12] = '{0,0,1,32'h1c000020,0,32'h0,0,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[13] = '{0,0,1,32'h1c000024,0,32'h0,0,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[14] = '{1,0,1,32'h1c000028,0,32'h0,0,        2'b00,32'h0,32'h0,2'b00,0,3'd0};
    tbl[15] = '{0,0,1,32'h1c008000,0,32'h0,0,        2'b00,32'h0,32'h0,2'b00,0,3'd0};
    tbl[16] = '{0,0,1,32'h1c008000,1,32'h0000dead,0, 2'b00,32'h0,32'h0,2'b00,0,3'd0};
    tbl[17] = '{0,0,1,32'h1c008000,1,32'h0000beef,0, 2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[18] = '{0,0,0,32'h0,1,32'h00100000,1,        2'b00,32'h0,32'h0,2'b00,1,3'd0};
    tbl[19] = '{0,0,0,32'h0,0,32'h0,1,               2'b01,32'h1c008000,32'h00100000,2'b00,1,3'd1};

    rst = 1'b1;
    drv(0,0,0,32'h0,0,32'h0,0);
    @(negedge clk);
    advance();
    rst = 1'b0;
    #1;
    chk("rst_allowin", 64'(allow_o), 64'd1);
    chk("rst_valid",   64'(valid_o), 64'd0);
    chk("rst_count",   64'(cnt_o), 64'd0);
    chk("rst_pc",      pc_o, 64'd0);
    chk("rst_excep",   64'(excep_o | int_o | adef_o), 64'd0);
    advance();

    // Directed vectors: single fetch, misaligned PC, interrupt, flush
    for (int i = 0; i < 20; i++) begin
      drv(tbl[i].f, tbl[i].i, tbl[i].v, tbl[i].p, tbl[i].d, tbl[i].r, tbl[i].a);
      #1;
      chk($sformatf("tv%0d_valid", i),   64'(valid_o), 64'(tbl[i].ev));
      chk($sformatf("tv%0d_pc0", i),     64'(pc_o[31:0]), 64'(tbl[i].epc0));
      chk($sformatf("tv%0d_inst0", i),   64'(inst_o[31:0]), 64'(tbl[i].einst0));
      chk($sformatf("tv%0d_excep", i),   64'(excep_o), 64'(tbl[i].eex));
      chk($sformatf("tv%0d_allowin", i), 64'(allow_o), 64'(tbl[i].eal));
      chk($sformatf("tv%0d_count", i),   64'(cnt_o), 64'(tbl[i].ecnt));
      check_model();
      advance();
    end

    // Back-pressure: fill all four slots, then drain two per cycle
    drv(0,0,1,32'h1c000000,0,32'h0,0);  cyc();
    drv(0,0,1,32'h1c000004,0,32'h0,0);  cyc();
    drv(0,0,0,32'h0,1,32'h11,0);        cyc();
    drv(0,0,1,32'h1c000008,1,32'h22,0); cyc();
    drv(0,0,1,32'h1c00000c,0,32'h0,0);  cyc();
    drv(0,0,0,32'h0,1,32'h33,0);        cyc();
    drv(0,0,0,32'h0,1,32'h44,0);        cyc();
    drv(0,0,1,32'h1c000010,0,32'h0,0);
    #1;
    chk("bp_full_count", 64'(cnt_o), 64'd4);
    chk("bp_full_allow", 64'(allow_o), 64'd0);
    check_model();
    advance();
    drv(0,0,0,32'h0,0,32'h0,1);
    #1;
    chk("bp_drain0_valid", 64'(valid_o), 64'd3);
    chk("bp_drain0_pc", pc_o, 64'h1c000004_1c000000);
    check_model();
    advance();
    #1;
    chk("bp_drain1_valid", 64'(valid_o), 64'd3);
    chk("bp_drain1_pc", pc_o, 64'h1c00000c_1c000008);
    check_model();
    advance();
    #1;
    chk("bp_empty_count", 64'(cnt_o), 64'd0);
    advance();

    // Reset with three buffered entries and one request outstanding
    drv(0,0,1,32'h1c000100,0,32'h0,0);  cyc();
    drv(0,0,1,32'h1c000104,0,32'h0,0);  cyc();
    drv(0,0,0,32'h0,1,32'h55,0);        cyc();
    drv(0,0,1,32'h1c000108,1,32'h66,0); cyc();
    drv(0,0,0,32'h0,1,32'h77,0);        cyc();
    drv(0,0,1,32'h1c00010c,0,32'h0,0);
    #1;
    chk("mrst_pre_count", 64'(cnt_o), 64'd3);
    check_model();
    advance();
    rst = 1'b1;
    drv(0,0,0,32'h0,0,32'h0,0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst_count", 64'(cnt_o), 64'd0);
    chk("mrst_valid", 64'(valid_o), 64'd0);
    chk("mrst_allow", 64'(allow_o), 64'd1);
    check_model();
    advance();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      rp  = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      pct = ((i / 300) % 2 == 1) ? 20 : 85;
      drv($urandom_range(0, 24) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1,
          rp,
          ((mpend.size() + mcancel) > 0) && ($urandom_range(0, 1) == 1),
          $urandom,
          $urandom_range(0, 99) < pct);
      cyc();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
